// File: rtl/conv_pkg.sv
// Shared geometry and state encoding for the layer-1 convolution frame sequencer.
package conv_pkg;
  localparam int unsigned IMG_W   = 28;
  localparam int unsigned IMG_H   = 28;
  localparam int unsigned K       = 5;
  localparam int unsigned OUT_W   = IMG_W - K + 1;
  localparam int unsigned OUT_H   = IMG_H - K + 1;
  localparam int unsigned OUT_PIX = OUT_W * OUT_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/conv_layer_ctrl_if.sv
// Nios pixel stream: valid/ready handshake carrying one 8-bit pixel per accept.
interface conv_layer_ctrl_if;
  logic       s_valid;
  logic [7:0] s_pixel;
  logic       s_ready;

  modport master (output s_valid, output s_pixel, input s_ready);
  modport slave  (input s_valid, input s_pixel, output s_ready);
endinterface

// File: rtl/frame_pos_counter.sv
// Raster row/column position within a W x H frame, wrapping to (0,0) after the last pixel.
module frame_pos_counter #(
  parameter int unsigned W  = 28,
  parameter int unsigned H  = 28,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  assign last = (row == CW'(H - 1)) && (col == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == CW'(W - 1)) begin
        col <= '0;
        row <= last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end
endmodule

// File: rtl/conv_layer_ctrl.sv
// Frame sequencer: accepts a pixel frame, tags complete 5x5 windows for the PE,
// counts PE results and signals frame completion.
module conv_layer_ctrl #(
  parameter int unsigned IMG_W = conv_pkg::IMG_W,
  parameter int unsigned IMG_H = conv_pkg::IMG_H,
  parameter int unsigned K     = conv_pkg::K,
  parameter int unsigned CW    = 5,
  parameter int unsigned RCW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  conv_layer_ctrl_if.slave pix,
  output logic            win_shift,
  output logic [7:0]      win_pixel,
  output logic            win_valid,
  output logic            win_sop,
  output logic            win_eop,
  output logic [CW-1:0]   out_row,
  output logic [CW-1:0]   out_col,
  input  logic            pe_result_valid,
  output logic            busy,
  output logic            done,
  output logic            err
);
  import conv_pkg::*;

  localparam int unsigned EXP_RES = (IMG_W - K + 1) * (IMG_H - K + 1);

  state_t         state, state_nxt;
  logic           accept, last, frame_clr, win_ok, done_nxt;
  logic           res_inc, err_set;
  logic [CW-1:0]  row, col;
  logic [RCW-1:0] res_cnt, res_nxt;

  assign accept    = pix.s_valid & pix.s_ready;
  assign frame_clr = (state == ST_IDLE) && start;

  frame_pos_counter #(.W(IMG_W), .H(IMG_H), .CW(CW)) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (frame_clr),
    .adv  (accept),
    .row  (row),
    .col  (col),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Completion looks at the post-increment count so done follows the final result by one cycle.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (res_nxt == RCW'(EXP_RES)) begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pix.s_ready = (state == ST_LOAD);
    busy        = (state != ST_IDLE);
  end

  assign res_inc = pe_result_valid && (state != ST_IDLE);
  assign res_nxt = (res_inc && (res_cnt != '1)) ? res_cnt + RCW'(1) : res_cnt;
  assign err_set = (pe_result_valid && (state == ST_IDLE)) ||
                   (res_inc && (res_nxt > RCW'(EXP_RES)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      res_cnt <= frame_clr ? '0 : res_nxt;
      done    <= done_nxt;
      err     <= (err & ~frame_clr) | err_set;
    end
  end

  assign win_ok = accept && (row >= CW'(K - 1)) && (col >= CW'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_shift <= 1'b0;
      win_pixel <= '0;
      win_valid <= 1'b0;
      win_sop   <= 1'b0;
      win_eop   <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      win_shift <= accept;
      win_pixel <= accept ? pix.s_pixel : '0;
      win_valid <= win_ok;
      win_sop   <= win_ok && (row == CW'(K - 1)) && (col == CW'(K - 1));
      win_eop   <= win_ok && last;
      out_row   <= win_ok ? row - CW'(K - 1) : '0;
      out_col   <= win_ok ? col - CW'(K - 1) : '0;
    end
  end
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: per-cycle comparison against a transaction-level frame model.
module tb_conv_layer_ctrl;
  import conv_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NRES = OUT_PIX;

  logic       clk = 1'b0;
  logic       rst, start, pe;
  logic       win_shift, win_valid, win_sop, win_eop, busy, done, err;
  logic [7:0] win_pixel;
  logic [4:0] out_row, out_col;

  conv_layer_ctrl_if pix ();

  conv_layer_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CW(5), .RCW(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pix             (pix),
    .win_shift       (win_shift),
    .win_pixel       (win_pixel),
    .win_valid       (win_valid),
    .win_sop         (win_sop),
    .win_eop         (win_eop),
    .out_row         (out_row),
    .out_col         (out_col),
    .pe_result_valid (pe),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Frame model: progress measured in pixels accepted and results seen.
  bit       m_active, m_err;
  int       m_loaded, m_results;
  bit       e_shift, e_valid, e_sop, e_eop, e_done;
  bit [7:0] e_pix;
  int       e_row, e_col;

  int shift_cnt, valid_cnt, done_cnt, sop_cnt, eop_cnt, sop_pix, eop_pos;

  typedef struct {
    int vmode;
    int pmode;
    int nres;
    bit prand;
    int exp_done;
    bit exp_err;
  } vec_t;

  task automatic model_reset();
    m_active = 0; m_err = 0; m_loaded = 0; m_results = 0;
    e_shift = 0; e_valid = 0; e_sop = 0; e_eop = 0; e_done = 0;
    e_pix = 0; e_row = 0; e_col = 0;
  endtask

  task automatic model_step();
    bit load, drain, acc;
    int r, c;
    load  = m_active && (m_loaded < NPIX);
    drain = m_active && (m_loaded == NPIX);
    acc   = load && pix.s_valid;
    r = m_loaded / int'(IMG_W);
    c = m_loaded % int'(IMG_W);
    e_shift = acc;
    e_pix   = acc ? pix.s_pixel : 8'd0;
    e_valid = acc && (r >= int'(K) - 1) && (c >= int'(K) - 1);
    e_row   = e_valid ? r - (int'(K) - 1) : 0;
    e_col   = e_valid ? c - (int'(K) - 1) : 0;
    e_sop   = e_valid && (e_row == 0) && (e_col == 0);
    e_eop   = e_valid && (e_row == int'(OUT_H) - 1) && (e_col == int'(OUT_W) - 1);
    e_done  = 0;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_loaded = 0; m_results = 0; m_err = pe;
      end else if (pe) m_err = 1;
    end else begin
      if (acc) m_loaded++;
      if (pe) begin
        if (m_results < 1023) m_results++;
        if (m_results > NRES) m_err = 1;
      end
      if (drain && (m_results == NRES)) begin
        e_done = 1; m_active = 0;
      end
    end
  endtask

  task automatic compare_all(input string name);
    logic [25:0] act, exp;
    logic [4:0]  er, ec;
    er  = 5'(e_row);
    ec  = 5'(e_col);
    act = {pix.s_ready, win_shift, win_pixel, win_valid, win_sop, win_eop,
           out_row, out_col, busy, done, err};
    exp = {m_active && (m_loaded < NPIX), e_shift, e_pix, e_valid, e_sop, e_eop,
           er, ec, m_active, e_done, m_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t {rdy,sh,pix,v,sop,eop,row,col,busy,done,err} act=%h exp=%h",
               name, $time, act, exp);
    end
    if (win_shift === 1'b1) shift_cnt++;
    if (win_valid === 1'b1) valid_cnt++;
    if (done === 1'b1) done_cnt++;
    if (win_sop === 1'b1) begin sop_cnt++; sop_pix = win_pixel; end
    if (win_eop === 1'b1) begin eop_cnt++; eop_pos = out_row * 100 + out_col; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all("cycle");
  endtask

  task automatic clear_obs();
    shift_cnt = 0; valid_cnt = 0; done_cnt = 0; sop_cnt = 0; eop_cnt = 0;
    sop_pix = -1; eop_pos = -1;
  endtask

  // vmode: 0 back-to-back, 1 one-on/two-off, 2 random. pmode 1 interleaves results with loading.
  task automatic run_frame(input int vmode, input int pmode, input int nres, input bit prand);
    int phase, sent, guard;
    bit loading;
    clear_obs();
    start = 1;
    tick();
    start = 0;
    sent = 0; phase = 0; guard = 0;
    while (((m_active && m_loaded < NPIX) || sent < nres) && guard < 20000) begin
      loading = m_active && (m_loaded < NPIX);
      if (!loading)        pix.s_valid = 1'($urandom_range(0, 1));
      else if (vmode == 0) pix.s_valid = 1;
      else if (vmode == 1) pix.s_valid = (phase % 3 == 0);
      else                 pix.s_valid = 1'($urandom_range(0, 1));
      pix.s_pixel = prand ? 8'($urandom) : 8'(m_loaded % 256);
      pe = (sent < nres) && (!loading || (pmode == 1 && $urandom_range(0, 3) == 0));
      if (pe) sent++;
      tick();
      phase++; guard++;
    end
    pix.s_valid = 0; pe = 0;
    check("frame_cycle_budget", int'(guard < 20000), 1);
    repeat (3) tick();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{vmode: 0, pmode: 0, nres: 576, prand: 0, exp_done: 1, exp_err: 0};
    tbl[1] = '{vmode: 1, pmode: 0, nres: 576, prand: 0, exp_done: 1, exp_err: 0};
    tbl[2] = '{vmode: 2, pmode: 1, nres: 576, prand: 1, exp_done: 1, exp_err: 0};
    tbl[3] = '{vmode: 0, pmode: 0, nres: 575, prand: 0, exp_done: 0, exp_err: 0};
    tbl[4] = '{vmode: 0, pmode: 1, nres: 577, prand: 0, exp_done: 1, exp_err: 1};

    rst = 1; start = 0; pe = 0; pix.s_valid = 0; pix.s_pixel = 0;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    compare_all("reset_state");
    rst = 0;
    tick();

    // Result strobe while idle is an error until the next start.
    pe = 1;
    tick();
    pe = 0;
    check("err_idle_result", int'(err), 1);
    start = 1;
    tick();
    start = 0;
    check("err_cleared_by_start", int'(err), 0);

    for (int i = 0; i < 400 && m_loaded < 300; i++) begin
      pix.s_valid = 1; pix.s_pixel = 8'(m_loaded % 256);
      tick();
    end
    // Pixel 300 sits at row 10 col 20, i.e. output position 6/16.
    start = 1; pix.s_pixel = 8'(300 % 256);
    tick();
    start = 0;
    check("ignored_start_row", int'(out_row), 6);
    check("ignored_start_col", int'(out_col), 16);
    check("ignored_start_busy", int'(busy), 1);
    for (int i = 0; i < 400 && m_loaded < 400; i++) begin
      pix.s_pixel = 8'(m_loaded % 256);
      tick();
    end
    pix.s_valid = 0;

    rst = 1;
    #1;
    model_reset();
    check("reset_async_outputs",
          int'({pix.s_ready, win_shift, win_pixel, win_valid, win_sop, win_eop,
                out_row, out_col, busy, done, err}), 0);
    @(negedge clk);
    rst = 0;
    tick();

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t].vmode, tbl[t].pmode, tbl[t].nres, tbl[t].prand);
      check("shift_count", shift_cnt, 784);
      check("valid_count", valid_cnt, 576);
      check("sop_count", sop_cnt, 1);
      check("eop_count", eop_cnt, 1);
      check("eop_position", eop_pos, 2323);
      if (!tbl[t].prand) check("sop_pixel", sop_pix, 116);
      check("done_count", done_cnt, tbl[t].exp_done);
      check("err_flag", int'(err), int'(tbl[t].exp_err));
      check("busy_after_frame", int'(busy), tbl[t].exp_done == 0 ? 1 : 0);
      if (m_active) begin
        pe = 1;
        tick();
        pe = 0;
        repeat (2) tick();
        check("done_after_final_result", done_cnt, 1);
        check("idle_after_final_result", int'(busy), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
